// File: rtl/mycpu_wb_stage.sv
// Write-back stage: owns the MEM/WB register, performs load extraction from the
// SRAM read data, and drives the regfile write port, forwarding bus and trace.
module mycpu_wb_stage #(
  parameter logic [31:0] PC_RESET = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [5:0]  ms_lsmode,
  input  logic [1:0]  ms_addr_low,
  input  logic [31:0] ms_alu_result,
  input  logic [31:0] ms_rt_cont,
  input  logic        ms_rf_wen,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_fwd_valid,
  output logic [4:0]  ws_fwd_dest,
  output logic [31:0] ws_fwd_data,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic        wsValid;
  logic        firstCyc;
  logic [31:0] rdataBuf;
  logic [31:0] pc;
  logic [5:0]  lsmode;
  logic [1:0]  addrLow;
  logic [31:0] aluResult;
  logic [31:0] rtCont;
  logic        rfWen;
  logic [4:0]  dest;

  logic        accept;
  logic [31:0] src;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadResult;
  logic [31:0] wdata;
  logic        destNonZero;
  logic        unusedStoreBit;

  assign ws_allowin = !wsValid || !ws_stall;
  assign accept     = ms_to_ws_valid && ws_allowin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wsValid   <= 1'b0;
      pc        <= PC_RESET;
      lsmode    <= '0;
      addrLow   <= '0;
      aluResult <= '0;
      rtCont    <= '0;
      rfWen     <= 1'b0;
      dest      <= '0;
    end else if (ws_allowin) begin
      wsValid <= ms_to_ws_valid;
      if (ms_to_ws_valid) begin
        pc        <= ms_pc;
        lsmode    <= ms_lsmode;
        addrLow   <= ms_addr_low;
        aluResult <= ms_alu_result;
        rtCont    <= ms_rt_cont;
        rfWen     <= ms_rf_wen;
        dest      <= ms_dest;
      end
    end
  end

  // The SRAM only presents read data in the first WB cycle, so capture it then
  // regardless of stall; firstCyc must drop even while the stage is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      firstCyc <= 1'b0;
      rdataBuf <= '0;
    end else begin
      firstCyc <= accept;
      if (wsValid && firstCyc) rdataBuf <= data_sram_rdata;
    end
  end

  assign src     = firstCyc ? data_sram_rdata : rdataBuf;
  assign byteSel = src[8*addrLow +: 8];
  assign halfSel = src[16*addrLow[1] +: 16];

  always_comb begin
    loadResult = '0;
    case (lsmode[3:1])
      3'b000: loadResult = {{24{byteSel[7] & ~lsmode[0]}}, byteSel};
      3'b001: loadResult = {{16{halfSel[15] & ~lsmode[0]}}, halfSel};
      3'b010: loadResult = src;
      3'b011: begin
        case (addrLow)
          2'b00:   loadResult = {src[7:0], rtCont[23:0]};
          2'b01:   loadResult = {src[15:0], rtCont[15:0]};
          2'b10:   loadResult = {src[23:0], rtCont[7:0]};
          default: loadResult = src;
        endcase
      end
      3'b100: begin
        case (addrLow)
          2'b00:   loadResult = src;
          2'b01:   loadResult = {rtCont[31:24], src[31:8]};
          2'b10:   loadResult = {rtCont[31:16], src[31:16]};
          default: loadResult = {rtCont[31:8], src[31:24]};
        endcase
      end
      default: loadResult = '0;
    endcase
  end

  assign wdata          = lsmode[5] ? loadResult : aluResult;
  assign destNonZero    = (dest != 5'd0);
  assign unusedStoreBit = lsmode[4];

  assign rf_we    = wsValid && rfWen && !ws_stall && destNonZero;
  assign rf_waddr = dest;
  assign rf_wdata = wdata;

  assign ws_fwd_valid = wsValid && rfWen && destNonZero;
  assign ws_fwd_dest  = dest;
  assign ws_fwd_data  = wdata;

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = dest;
  assign debug_wb_rf_wdata = wdata;

endmodule

// File: tb/tb_mycpu_wb_stage.sv
// Self-checking bench for mycpu_wb_stage: directed vector table, stall/reset
// sequences, and randomized traffic against a per-instruction reference model.
module tb_mycpu_wb_stage;

  localparam logic [31:0] PC_RST = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [5:0]  ms_lsmode;
  logic [1:0]  ms_addr_low;
  logic [31:0] ms_alu_result;
  logic [31:0] ms_rt_cont;
  logic        ms_rf_wen;
  logic [4:0]  ms_dest;
  logic [31:0] data_sram_rdata;
  logic        ws_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mycpu_wb_stage #(.PC_RESET(PC_RST)) dut (
    .clk(clk), .rst(rst),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_lsmode(ms_lsmode), .ms_addr_low(ms_addr_low),
    .ms_alu_result(ms_alu_result), .ms_rt_cont(ms_rt_cont),
    .ms_rf_wen(ms_rf_wen), .ms_dest(ms_dest),
    .data_sram_rdata(data_sram_rdata), .ws_stall(ws_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: byte lanes via shifts and masks, not per-case bit slicing.
  function automatic logic [31:0] refWdata(input logic [5:0] ls, input logic [1:0] al,
                                           input logic [31:0] alu, input logic [31:0] rt,
                                           input logic [31:0] src);
    logic [31:0] v;
    int a;
    a = int'(al);
    if (!ls[5]) return alu;
    case (ls[3:1])
      3'd0: begin
        v = (src >> (8 * a)) & 32'hFF;
        if (!ls[0] && v[7]) v = v | 32'hFFFF_FF00;
        return v;
      end
      3'd1: begin
        v = (src >> (16 * (a / 2))) & 32'hFFFF;
        if (!ls[0] && v[15]) v = v | 32'hFFFF_0000;
        return v;
      end
      3'd2: return src;
      3'd3: return (src << (8 * (3 - a))) | (rt & (32'hFFFF_FFFF >> (8 * (a + 1))));
      3'd4: return (src >> (8 * a)) | (rt & ~(32'hFFFF_FFFF >> (8 * a)));
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic [5:0]  ls;
    logic [1:0]  al;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic        wen;
    logic [4:0]  dest;
    logic        expWe;
    logic [31:0] expData;
  } vec_t;

  vec_t vt[13];

  task automatic driveInstr(input logic [5:0] ls, input logic [1:0] al, input logic [31:0] alu,
                            input logic [31:0] rt, input logic wen, input logic [4:0] dst,
                            input logic [31:0] pc);
    ms_to_ws_valid = 1'b1;
    ms_lsmode = ls; ms_addr_low = al; ms_alu_result = alu;
    ms_rt_cont = rt; ms_rf_wen = wen; ms_dest = dst; ms_pc = pc;
  endtask

  // Random-phase model state: the held instruction and its captured read data.
  logic        mValid, mFirst;
  logic [5:0]  mLs;
  logic [1:0]  mAl;
  logic [31:0] mAlu, mRt, mPc, mCap;
  logic        mWen;
  logic [4:0]  mDest;

  initial begin
    vt[0]  = '{6'b100000, 2'b01, 32'h0, 32'h0, 32'h1234_8056, 1'b1, 5'd3, 1'b1, 32'hFFFF_FF80};
    vt[1]  = '{6'b100001, 2'b01, 32'h0, 32'h0, 32'h1234_8056, 1'b1, 5'd3, 1'b1, 32'h0000_0080};
    vt[2]  = '{6'b100011, 2'b10, 32'h0, 32'h0, 32'hBEEF_1234, 1'b1, 5'd4, 1'b1, 32'h0000_BEEF};
    vt[3]  = '{6'b100010, 2'b10, 32'h0, 32'h0, 32'hBEEF_1234, 1'b1, 5'd4, 1'b1, 32'hFFFF_BEEF};
    vt[4]  = '{6'b100100, 2'b00, 32'h0, 32'h0, 32'hBEEF_1234, 1'b1, 5'd5, 1'b1, 32'hBEEF_1234};
    vt[5]  = '{6'b100110, 2'b01, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 5'd6, 1'b1, 32'h3344_CCDD};
    vt[6]  = '{6'b100110, 2'b11, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 5'd6, 1'b1, 32'h1122_3344};
    vt[7]  = '{6'b101000, 2'b10, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 5'd6, 1'b1, 32'hAABB_1122};
    vt[8]  = '{6'b000000, 2'b00, 32'h5, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0000_0005};
    vt[9]  = '{6'b000000, 2'b00, 32'h5, 32'h0, 32'h0, 1'b1, 5'd7, 1'b1, 32'h0000_0005};
    vt[10] = '{6'b010100, 2'b00, 32'h40, 32'h1, 32'h9999_9999, 1'b0, 5'd8, 1'b0, 32'h0000_0040};
    vt[11] = '{6'b101110, 2'b00, 32'h77, 32'h0, 32'h1234_5678, 1'b1, 5'd9, 1'b1, 32'h0000_0000};
    vt[12] = '{6'b101000, 2'b01, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 5'd10, 1'b1, 32'hAA11_2233};

    rst = 1'b1;
    ms_to_ws_valid = 0; ms_pc = 0; ms_lsmode = 0; ms_addr_low = 0; ms_alu_result = 0;
    ms_rt_cont = 0; ms_rf_wen = 0; ms_dest = 0; data_sram_rdata = 0; ws_stall = 0;
    #1;
    chk("rst_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_fwd_valid", 32'(ws_fwd_valid), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_pc", debug_wb_pc, PC_RST);
    chk("rst_dbg_wen", 32'(debug_wb_rf_wen), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed table: one instruction at a time, read data in the first WB cycle.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      driveInstr(vt[i].ls, vt[i].al, vt[i].alu, vt[i].rt, vt[i].wen, vt[i].dest, 32'h1000 + 32'(4 * i));
      data_sram_rdata = $urandom;
      @(negedge clk);
      ms_to_ws_valid = 0;
      data_sram_rdata = vt[i].rdata;
      #1;
      chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(vt[i].expWe));
      chk($sformatf("v%0d_wdata", i), rf_wdata, vt[i].expData);
      chk($sformatf("v%0d_fwd_valid", i), 32'(ws_fwd_valid), 32'(vt[i].expWe));
      chk($sformatf("v%0d_fwd_data", i), ws_fwd_data, vt[i].expData);
      chk($sformatf("v%0d_dbg_wen", i), 32'(debug_wb_rf_wen), vt[i].expWe ? 32'hF : 32'h0);
      chk($sformatf("v%0d_pc", i), debug_wb_pc, 32'h1000 + 32'(4 * i));
      if (vt[i].expWe) chk($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(vt[i].dest));
      @(negedge clk);
      data_sram_rdata = 32'h0;
      #1;
      chk($sformatf("v%0d_we_once", i), 32'(rf_we), 32'd0);
    end

    // Stall across changing read data; release overlaps the next acceptance.
    @(negedge clk);
    driveInstr(6'b100100, 2'b00, 32'h0, 32'h0, 1'b1, 5'd12, 32'h2000);
    @(negedge clk);
    ms_to_ws_valid = 0; ws_stall = 1; data_sram_rdata = 32'hCAFE_F00D;
    #1;
    chk("st0_allowin", 32'(ws_allowin), 32'd0);
    chk("st0_we", 32'(rf_we), 32'd0);
    chk("st0_fwd_valid", 32'(ws_fwd_valid), 32'd1);
    chk("st0_fwd_data", ws_fwd_data, 32'hCAFE_F00D);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      data_sram_rdata = 32'hDEAD_DEAD;
      #1;
      chk($sformatf("st%0d_allowin", k), 32'(ws_allowin), 32'd0);
      chk($sformatf("st%0d_we", k), 32'(rf_we), 32'd0);
      chk($sformatf("st%0d_wdata", k), rf_wdata, 32'hCAFE_F00D);
    end
    @(negedge clk);
    ws_stall = 0;
    driveInstr(6'b000000, 2'b00, 32'h99, 32'h0, 1'b1, 5'd9, 32'h2004);
    #1;
    chk("st_rel_allowin", 32'(ws_allowin), 32'd1);
    chk("st_rel_we", 32'(rf_we), 32'd1);
    chk("st_rel_wdata", rf_wdata, 32'hCAFE_F00D);
    chk("st_rel_waddr", 32'(rf_waddr), 32'd12);
    @(negedge clk);
    ms_to_ws_valid = 0;
    #1;
    chk("st_next_we", 32'(rf_we), 32'd1);
    chk("st_next_waddr", 32'(rf_waddr), 32'd9);
    chk("st_next_wdata", rf_wdata, 32'h99);
    chk("st_next_pc", debug_wb_pc, 32'h2004);

    // Reset while a load is held by stall.
    @(negedge clk);
    driveInstr(6'b100100, 2'b00, 32'h0, 32'h0, 1'b1, 5'd14, 32'h3000);
    @(negedge clk);
    ms_to_ws_valid = 0; ws_stall = 1; data_sram_rdata = 32'h1111_2222;
    @(negedge clk);
    rst = 1;
    #1;
    chk("rs_we", 32'(rf_we), 32'd0);
    chk("rs_allowin", 32'(ws_allowin), 32'd1);
    chk("rs_fwd_valid", 32'(ws_fwd_valid), 32'd0);
    chk("rs_wdata", rf_wdata, 32'd0);
    chk("rs_pc", debug_wb_pc, PC_RST);
    @(negedge clk);
    rst = 0; ws_stall = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rs_after%0d_we", k), 32'(rf_we), 32'd0);
    end

    // Randomized traffic against the per-instruction model.
    mValid = 0; mFirst = 0; mCap = 0;
    mLs = 0; mAl = 0; mAlu = 0; mRt = 0; mPc = 0; mWen = 0; mDest = 0;
    for (int c = 0; c < 600; c++) begin
      logic expAllow, expWe, expFwd;
      @(negedge clk);
      ws_stall = ($urandom_range(0, 99) < 40);
      data_sram_rdata = $urandom;
      driveInstr(6'($urandom), 2'($urandom), $urandom, $urandom, 1'($urandom_range(0, 3) != 0),
                 5'($urandom), $urandom);
      ms_to_ws_valid = ($urandom_range(0, 99) < 70);
      if (mValid && mFirst) mCap = data_sram_rdata;
      expAllow = !mValid || !ws_stall;
      expFwd = mValid && mWen && (mDest != 0);
      expWe = expFwd && !ws_stall;
      #1;
      chk("rnd_allowin", 32'(ws_allowin), 32'(expAllow));
      chk("rnd_we", 32'(rf_we), 32'(expWe));
      chk("rnd_fwd_valid", 32'(ws_fwd_valid), 32'(expFwd));
      if (mValid) begin
        chk("rnd_wdata", rf_wdata, refWdata(mLs, mAl, mAlu, mRt, mCap));
        chk("rnd_pc", debug_wb_pc, mPc);
        chk("rnd_dest", 32'(rf_waddr), 32'(mDest));
      end
      if (expAllow) begin
        mValid = ms_to_ws_valid;
        mFirst = ms_to_ws_valid;
        if (ms_to_ws_valid) begin
          mLs = ms_lsmode; mAl = ms_addr_low; mAlu = ms_alu_result; mRt = ms_rt_cont;
          mWen = ms_rf_wen; mDest = ms_dest; mPc = ms_pc;
        end
      end else begin
        mFirst = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mycpu_wb_stage.md
Name: mycpu_wb_stage

Overview:
Write-back stage of the 5-stage MIPS pipeline. It sits directly downstream of the MEM stage and owns the MEM/WB pipeline register. It captures the synchronous data-SRAM read data and performs load extraction (LB/LBU/LH/LHU/LW/LWL/LWR), then drives the regfile write port, the forwarding bus and the debug trace. A valid/allowin handshake lets WB hold an instruction under stall without losing its SRAM read data.

Parameters:
- PC_RESET, 32'hBFC0_0000, value of the held PC after reset (trace only)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ms_to_ws_valid  in  1  MEM holds a valid instruction for WB
- ws_allowin  out  1  WB can accept a new instruction this cycle
- ms_pc  in  32  instruction PC
- ms_lsmode  in  6  [5] load, [4] store, [3:1] size (000 B, 001 H, 010 W, 011 L, 100 R), [0] zero-extend
- ms_addr_low  in  2  effective address bits [1:0]
- ms_alu_result  in  32  ALU result, the write data for non-loads
- ms_rt_cont  in  32  rt value, the merge source for LWL/LWR
- ms_rf_wen  in  1  instruction writes the regfile
- ms_dest  in  5  destination register
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the MEM-stage read
- ws_stall  in  1  external hold of WB
- rf_we  out  1  regfile write enable
- rf_waddr  out  5  regfile write address
- rf_wdata  out  32  regfile write data
- ws_fwd_valid  out  1  forwarding entry valid
- ws_fwd_dest  out  5  forwarding destination
- ws_fwd_data  out  32  forwarding data (same as rf_wdata)
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_wen  out  4  trace byte write enables
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  32  trace write data

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock.
  - ws_valid=0, first_cyc=0, rdata_buf=0.
  - Payload registers are 0 and the held PC is PC_RESET.
  - All outputs read as deasserted or 0, and ws_allowin=1.
- Handshake:
  - ws_allowin = !ws_valid || !ws_stall.
  - At a posedge with ws_allowin=1, ws_valid takes ms_to_ws_valid.
  - The payload (pc, lsmode, addr_low, alu_result, rt_cont, rf_wen, dest) is latched only when ms_to_ws_valid && ws_allowin.
  - When ws_allowin=0, all registers hold.
- Read-data capture:
  - first_cyc is set on acceptance and cleared at the next edge.
  - When ws_valid && first_cyc, rdata_buf takes data_sram_rdata at the edge.
  - The load source is data_sram_rdata when first_cyc, otherwise rdata_buf. This stays correct through any stall length.
- Byte and half select: byte = src[8*addr_low +: 8]; half = src[16*addr_low[1] +: 16].
  - Sign-extend when lsmode[0]=0, zero-extend when lsmode[0]=1.
  - LH/LW misalignment never reaches WB (an upstream exception), so addr_low[0] is ignored for halves.
- LW returns src.
- LWL by addr_low:
  - 00: {src[7:0], rt[23:0]}
  - 01: {src[15:0], rt[15:0]}
  - 10: {src[23:0], rt[7:0]}
  - 11: src
- LWR by addr_low:
  - 00: src
  - 01: {rt[31:24], src[31:8]}
  - 10: {rt[31:16], src[31:16]}
  - 11: {rt[31:8], src[31:24]}
- Final data: wdata = lsmode[5] ? load_result : alu_result.
  - A size code of 101–111 on a load gives 0.
- Write commit: rf_we = ws_valid && rf_wen && !ws_stall && dest!=0.
  - rf_waddr = dest and rf_wdata = wdata.
  - Exactly one commit occurs per instruction, in its final (unstalled) WB cycle.
- Forwarding: ws_fwd_valid = ws_valid && rf_wen && dest!=0, asserted during stall cycles as well; ws_fwd_data = wdata.
- Trace: debug_wb_rf_wen = {4{rf_we}}; debug_wb_rf_wnum = dest; debug_wb_rf_wdata = wdata; debug_wb_pc = held pc.
- Simultaneous events: the last stalled cycle (ws_stall falls) commits, and the next instruction is accepted at the same edge.
- Reset mid-stall: the held instruction is discarded with no commit.
- Stores (lsmode[4]=1, rf_wen=0) pass through WB without a write.

Test Plan:
- LB, addr_low=01, rdata=0x12348056, lsmode[0]=0 -> rf_wdata=0xFFFFFF80; the same with LBU -> 0x00000080; rf_we high for exactly 1 cycle.
- LHU, addr_low=10, rdata=0xBEEF1234 -> 0x0000BEEF; LH -> 0xFFFFBEEF; LW -> 0xBEEF1234.
- LWL with rt=0xAABBCCDD, rdata=0x11223344:
  - addr_low=01 -> 0x3344CCDD; addr_low=11 -> 0x11223344.
  - LWR, addr_low=10 -> 0xAABB1122.
- Stall test: accept LW with rdata=0xCAFEF00D, hold ws_stall=1 for 3 cycles while rdata changes to 0xDEADDEAD.
  - ws_allowin=0 throughout; a single commit of 0xCAFEF00D follows ws_stall falling.
  - The next instruction is accepted at that same edge.
- ALU op with dest=0 and alu_result=0x5 -> rf_we=0 and ws_fwd_valid=0; the same with dest=7 -> rf_we=1, waddr=7, wdata=5, debug_wb_rf_wen=4'hF.
- Reset during a stalled LW -> outputs 0 immediately, no write after reset, ws_allowin=1.
